// File: rtl/shift_min_sequencer.sv
// shift_min_sequencer
// -------------------
// Reduces NUM_CAND shift-table candidates for one text window to their
// unsigned minimum. The result is held until the consumer takes it. A zero
// result raises out_match, which tells downstream that a candidate match
// needs verification.
//
// Optional feature: define SHIFT_MIN_EARLY_EXIT_EN to enable early exit. When
// a candidate of 0 is accepted, the window closes at once with a result of 0.
// The remaining candidates are not consumed, and upstream discards them.
// In the default build (macro undefined), every window consumes exactly
// NUM_CAND candidates.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/in_ready carries candidates into the sequencer, and
// out_valid/out_ready carries the window minimum out of it. in_ready and
// out_valid are registered and do not depend on in_valid or out_ready in the
// same cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        pulse that opens a window (honoured in IDLE, or in HOLD
//                together with out_ready)
//   in_valid     in_shift carries a candidate
//   in_ready     sequencer accepts a candidate this cycle (COLLECT)
//   in_shift     candidate shift value, WIDTH bits
//   out_valid    out_shift holds the window minimum (HOLD)
//   out_ready    consumer takes the result
//   out_shift    registered window minimum, WIDTH bits
//   out_match    out_shift == 0, decoded from the registered value only
//   busy         high in any state other than IDLE
//   o_dbg_state  current FSM state: 0 IDLE, 1 COLLECT, 2 HOLD
module shift_min_sequencer #(
  parameter int WIDTH    = 8,
  parameter int NUM_CAND = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_shift,
  output logic             out_match,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  // The counter holds 0..NUM_CAND, so it never wraps.
  localparam int CNT_W = $clog2(NUM_CAND + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out_shift;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic [WIDTH-1:0] w_min;
  logic             w_early;
  logic             w_close;

  // Running minimum that includes the candidate on the bus this cycle.
  assign w_min = (in_shift < r_acc) ? in_shift : r_acc;

`ifdef SHIFT_MIN_EARLY_EXIT_EN
  // A zero cannot be beaten, so the window may close immediately.
  assign w_early = (in_shift == '0);
`else
  assign w_early = 1'b0;
`endif

  // The candidate accepted this cycle is the last one for the window.
  assign w_close = (r_cnt == LAST_IDX) || w_early;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '1;
      r_cnt       <= '0;
      r_out_shift <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_COLLECT;
            r_acc      <= '1;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_COLLECT: begin
          // start is deliberately ignored while collecting.
          if (in_valid) begin
            r_acc <= w_min;
            r_cnt <= r_cnt + 1'b1;
            if (w_close) begin
              r_state     <= S_HOLD;
              r_out_shift <= w_min;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end
          end
        end

        S_HOLD: begin
          // out_shift stays frozen until the consumer takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (start) begin
              // Back-to-back window: no IDLE bubble.
              r_state    <= S_COLLECT;
              r_acc      <= '1;
              r_cnt      <= '0;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_shift   = r_out_shift;
  // Decoded from the register only, so there is no path from in_shift.
  assign out_match   = (r_out_shift == '0);
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: doc/shift_min_sequencer.md
SHIFT_MIN_SEQUENCER -- requirements
Module: shift_min_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each shift-table value.
REQ-002 SHALL have parameter NUM_CAND, default 4 (legal range 2..16): number of shift candidates reduced per text window.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: pulse that begins a new window reduction.
REQ-006 SHALL have port in_valid, input, 1: in_shift carries a valid candidate.
REQ-007 SHALL have port in_ready, output, 1: sequencer accepts a candidate this cycle.
REQ-008 SHALL have port in_shift, input, WIDTH: candidate shift value from the shift table.
REQ-009 SHALL have port out_valid, output, 1: out_shift holds the window minimum.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port out_shift, output, WIDTH: minimum shift for the window.
REQ-012 SHALL have port out_match, output, 1: high when out_shift equals 0, i.e. a candidate match needs verification.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, COLLECT and HOLD.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 -> COLLECT, accumulator loaded to all-ones, candidate counter cleared to 0.
REQ-016 COLLECT: in_ready=1; each in_valid&in_ready cycle SHALL update accumulator to min(accumulator, in_shift) (unsigned) and increment the counter.
REQ-017 COLLECT: accepting the NUM_CAND-th candidate -> HOLD, out_shift registered from min(accumulator, in_shift), out_valid high the following cycle (1-cycle latency from the last accept).
REQ-018 COLLECT with in_valid=0 SHALL hold accumulator and counter unchanged; no timeout.
REQ-019 HOLD: out_valid=1; out_shift and out_match SHALL stay stable until out_valid&out_ready.
REQ-020 HOLD with out_ready=1 and start=0 -> IDLE; HOLD with out_ready=1 and start=1 -> COLLECT directly, accumulator and counter re-initialised (back-to-back windows, no idle bubble).
REQ-021 start SHALL be ignored in COLLECT, and in HOLD while out_ready=0.
REQ-022 The counter SHALL be ceil(log2(NUM_CAND+1)) bits wide; it SHALL never wrap and SHALL never reach a value above NUM_CAND.
REQ-023 Equal candidates SHALL give that same value; a result of all-ones SHALL be legal, with no saturation.
REQ-024 out_match SHALL be derived only from the registered out_shift, so it never depends combinationally on in_shift.

Reset
REQ-025 rst=1 SHALL force state IDLE, accumulator to all-ones, counter to 0, out_shift to 0, out_valid, in_ready and busy to 0; out_match SHALL follow as 1 because out_shift is 0, but is qualified by out_valid.
REQ-026 rst asserted mid-COLLECT or mid-HOLD SHALL discard the partial result; the next cycle after release SHALL be IDLE.

Configuration
REQ-027 Macro SHIFT_MIN_EARLY_EXIT_EN SHALL control early termination.
REQ-028 With SHIFT_MIN_EARLY_EXIT_EN defined: accepting in_shift=0 in COLLECT -> HOLD immediately with out_shift=0; in_ready SHALL drop the next cycle; the remaining candidates SHALL not be consumed, and upstream discards them.
REQ-029 Without SHIFT_MIN_EARLY_EXIT_EN: exactly NUM_CAND candidates SHALL be consumed per window regardless of value.

Verification
REQ-030 WIDTH=8, NUM_CAND=4: start, then candidates 7,3,9,5 back-to-back -> out_valid one cycle after the 4th accept, out_shift=3, out_match=0.
REQ-031 Candidates 4,-,2,-,6,-,2 with in_valid gaps, out_ready held 0 for 5 cycles -> out_shift=2 stable for all 5 cycles, released on out_ready=1, then state IDLE.
REQ-032 out_ready=1 and start=1 in the same HOLD cycle, second window 1,1,1,1 -> no IDLE cycle between windows; second out_shift=1.
REQ-033 Candidates 5,0,8,8: with SHIFT_MIN_EARLY_EXIT_EN -> out_shift=0 and out_match=1 after 2 accepts, in_ready low afterwards; without the macro -> 4 accepts, out_shift=0.
REQ-034 rst pulsed after 2 of 4 candidates (255,255 already accepted) -> out_valid=0, busy=0; next window 255,255,255,255 -> out_shift=255.
REQ-035 start pulsed during COLLECT -> ignored; counter and accumulator continue unaffected.
